div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 137 +++++++++++++
 tb/tb_div_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Function : Round-robin arbiter sharing one iterative divider between two
//            requesters, with a watchdog that aborts a stalled divide.
// Revision : 1.0
// ============================================================================
module div_arbiter #(
   parameter int TIMEOUT = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] result,
   output logic        exception,
   output logic        timeout,
   output logic        busy,
   output logic        div_ctrl_DIV,
   output logic [31:0] div_operandA,
   output logic [31:0] div_operandB,
   input  logic [31:0] div_result,
   input  logic        div_exception,
   input  logic        div_resultRDY
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [5:0] c_CNT_LAST = 6'(TIMEOUT - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic        r_ptr;
   logic        r_id;
   logic [5:0]  r_cnt;
   logic [31:0] r_result;
   logic        r_exception;
   logic        r_timeout;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;

   logic        w_any_req;
   logic        w_grant_id;
   logic        w_cnt_expired;

   // Contention goes to the pointer's requester; otherwise whoever asked.
   assign w_any_req     = req0 | req1;
   assign w_grant_id    = (req0 & req1) ? r_ptr : req1;
   assign w_cnt_expired = (r_cnt == c_CNT_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_any_req) w_next = c_START;
         c_START: w_next = c_WAIT;
         c_WAIT:  if (div_resultRDY || w_cnt_expired) w_next = c_DONE;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      div_ctrl_DIV = (r_state == c_START);
      busy         = (r_state != c_IDLE);
      done0        = (r_state == c_DONE) && !r_id;
      done1        = (r_state == c_DONE) &&  r_id;
   end

   // Operands are captured only at grant so the divider sees a stable divisor.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr       <= 1'b0;
         r_id        <= 1'b0;
         r_cnt       <= 6'd0;
         r_result    <= 32'd0;
         r_exception <= 1'b0;
         r_timeout   <= 1'b0;
         r_op_a      <= 32'd0;
         r_op_b      <= 32'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_id   <= w_grant_id;
                  r_ptr  <= ~w_grant_id;
                  r_op_a <= w_grant_id ? a1 : a0;
                  r_op_b <= w_grant_id ? b1 : b0;
               end
            end
            c_START: begin
               r_cnt <= 6'd0;
            end
            c_WAIT: begin
               if (div_resultRDY) begin
                  r_result    <= div_result;
                  r_exception <= div_exception;
                  r_timeout   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
                  if (w_cnt_expired) begin
                     r_result    <= 32'd0;
                     r_exception <= 1'b1;
                     r_timeout   <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result       = r_result;
   assign exception    = r_exception;
   assign timeout      = r_timeout;
   assign div_operandA = r_op_a;
   assign div_operandB = r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// Bench for div_arbiter: a behavioural divider answers 34 cycles after START,
// expected completions are queued at request time and popped on done.
module tb_div_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] a0, b0, a1, b1;
   logic        done0, done1;
   logic [31:0] result;
   logic        exception, timeout, busy;
   logic        div_ctrl_DIV;
   logic [31:0] div_operandA, div_operandB;
   logic [31:0] div_result;
   logic        div_exception;
   logic        div_resultRDY;

   div_arbiter #(.TIMEOUT(40)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .done0(done0), .done1(done1),
      .result(result), .exception(exception), .timeout(timeout), .busy(busy),
      .div_ctrl_DIV(div_ctrl_DIV),
      .div_operandA(div_operandA), .div_operandB(div_operandB),
      .div_result(div_result), .div_exception(div_exception),
      .div_resultRDY(div_resultRDY)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        exc;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   n_div = 0;
   bit   both_seen = 0;
   bit   stuck = 0;
   bit   force_rdy = 0;
   bit   active = 0;
   int   dcnt = 0;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (div_ctrl_DIV) n_div++;
      if (done0 && done1) both_seen = 1;
   end

   // Divider model: ready in the 34th cycle after the START cycle.
   always @(negedge clock) begin
      div_resultRDY = force_rdy;
      if (reset) begin
         active = 0;
      end else if (div_ctrl_DIV) begin
         active = 1;
         dcnt = 0;
      end else if (active) begin
         dcnt++;
         if (dcnt == 34 && !stuck) begin
            div_resultRDY = 1'b1;
            div_exception = (div_operandB == 0);
            div_result    = (div_operandB == 0) ? 32'd0 : div_operandA / div_operandB;
            active = 0;
         end
      end
   end

   task automatic wait_done(output int id, output int at);
      id = -1;
      at = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (done0 || done1) begin
            id = done1 ? 1 : 0;
            at = cyc;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1; req0 = 0; req1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      repeat (3) @(negedge clock);
      n_vec++;
      if ({busy, done0, done1, div_ctrl_DIV, exception, timeout} !== 6'b0 ||
          result !== 0 || div_operandA !== 0 || div_operandB !== 0) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b%b div=%b exc=%b to=%b res=%0d opA=%0d opB=%0d, want all 0",
                  busy, done0, done1, div_ctrl_DIV, exception, timeout, result, div_operandA, div_operandB);
      end
      reset = 0;
   endtask

   task automatic test_basic();
      int id, at, c0, d0;
      exp_t e;
      a0 = 100; b0 = 7;
      c0 = cyc; d0 = n_div;
      req0 = 1;
      sb.push_back('{0, 32'd14, 1'b0, 1'b0});
      wait_done(id, at);
      req0 = 0;
      e = sb.pop_front();
      n_vec++;
      if (id !== e.id) begin n_err++; $display("FAIL basic_id: got %0d want %0d", id, e.id); end
      n_vec++;
      if (at - c0 !== 36) begin n_err++; $display("FAIL basic_latency: got %0d want 36", at - c0); end
      n_vec++;
      if (result !== e.res || exception !== e.exc || timeout !== e.to) begin
         n_err++;
         $display("FAIL basic_result: got res=%0d exc=%b to=%b want res=%0d exc=%b to=%b",
                  result, exception, timeout, e.res, e.exc, e.to);
      end
      n_vec++;
      if (n_div - d0 !== 1) begin n_err++; $display("FAIL basic_div_pulses: got %0d want 1", n_div - d0); end
      @(negedge clock);
      n_vec++;
      if (busy !== 1'b0 || done0 !== 1'b0) begin
         n_err++; $display("FAIL basic_after_done: busy=%b done0=%b want 0 0", busy, done0);
      end
   endtask

   task automatic test_round_robin();
      int id, at;
      exp_t e;
      reset = 1;
      @(negedge clock);
      reset = 0;
      a0 = 60; b0 = 3; a1 = 81; b1 = 9;
      req0 = 1; req1 = 1;
      sb.push_back('{0, 32'd20, 1'b0, 1'b0});
      sb.push_back('{1, 32'd9,  1'b0, 1'b0});
      sb.push_back('{0, 32'd20, 1'b0, 1'b0});
      for (int k = 0; k < 3; k++) begin
         wait_done(id, at);
         if (k == 2) begin req0 = 0; req1 = 0; end
         e = sb.pop_front();
         n_vec++;
         if (id !== e.id || result !== e.res || exception !== e.exc) begin
            n_err++;
            $display("FAIL rr_grant%0d: got id=%0d res=%0d exc=%b want id=%0d res=%0d exc=%b",
                     k, id, result, exception, e.id, e.res, e.exc);
         end
      end
      @(negedge clock);
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_div_by_zero();
      int id, at;
      exp_t e;
      a1 = 5; b1 = 0;
      req1 = 1;
      sb.push_back('{1, 32'd0, 1'b1, 1'b0});
      wait_done(id, at);
      req1 = 0;
      e = sb.pop_front();
      n_vec++;
      if (id !== e.id || result !== e.res || exception !== e.exc || timeout !== e.to) begin
         n_err++;
         $display("FAIL div_zero: got id=%0d res=%0d exc=%b to=%b want id=%0d res=%0d exc=%b to=%b",
                  id, result, exception, timeout, e.id, e.res, e.exc, e.to);
      end
      @(negedge clock);
   endtask

   task automatic test_timeout();
      int id, at, c0;
      bit bad;
      exp_t e;
      bad = 0;
      force_rdy = 1;
      repeat (6) begin
         @(negedge clock);
         if (busy || done0 || done1) bad = 1;
      end
      force_rdy = 0;
      repeat (2) @(negedge clock);
      n_vec++;
      if (bad) begin n_err++; $display("FAIL idle_rdy_ignored: busy/done seen with rdy in IDLE, want none"); end
      stuck = 1;
      a0 = 9; b0 = 3;
      c0 = cyc;
      req0 = 1;
      sb.push_back('{0, 32'd0, 1'b1, 1'b1});
      wait_done(id, at);
      req0 = 0;
      stuck = 0;
      e = sb.pop_front();
      n_vec++;
      if (at - c0 !== 42) begin n_err++; $display("FAIL timeout_latency: got %0d want 42", at - c0); end
      n_vec++;
      if (id !== e.id || result !== e.res || exception !== e.exc || timeout !== e.to) begin
         n_err++;
         $display("FAIL timeout_result: got id=%0d res=%0d exc=%b to=%b want id=%0d res=%0d exc=%b to=%b",
                  id, result, exception, timeout, e.id, e.res, e.exc, e.to);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      int id, at, c0;
      bit seen;
      exp_t e;
      a0 = 50; b0 = 5;
      req0 = 1;
      repeat (12) @(negedge clock);
      reset = 1;
      #1;
      n_vec++;
      if ({busy, done0, done1, div_ctrl_DIV, exception, timeout} !== 6'b0 ||
          result !== 0 || div_operandA !== 0 || div_operandB !== 0) begin
         n_err++;
         $display("FAIL reset_mid: busy=%b done=%b%b exc=%b to=%b res=%0d opA=%0d opB=%0d, want all 0",
                  busy, done0, done1, exception, timeout, result, div_operandA, div_operandB);
      end
      req0 = 0;
      repeat (2) @(negedge clock);
      reset = 0;
      seen = 0;
      repeat (50) begin
         @(negedge clock);
         if (done0 || done1 || busy) seen = 1;
      end
      n_vec++;
      if (seen) begin n_err++; $display("FAIL reset_discard: activity after reset, want none"); end
      a0 = 100; b0 = 7;
      c0 = cyc;
      req0 = 1;
      sb.push_back('{0, 32'd14, 1'b0, 1'b0});
      wait_done(id, at);
      req0 = 0;
      e = sb.pop_front();
      n_vec++;
      if (id !== e.id || result !== e.res || exception !== e.exc || at - c0 !== 36) begin
         n_err++;
         $display("FAIL reset_recover: got id=%0d res=%0d exc=%b lat=%0d want id=%0d res=%0d exc=%b lat=36",
                  id, result, exception, at - c0, e.id, e.res, e.exc);
      end
      @(negedge clock);
   endtask

   task automatic test_operand_hold();
      int id, at;
      exp_t e;
      a0 = 1000; b0 = 10;
      req0 = 1;
      sb.push_back('{0, 32'd100, 1'b0, 1'b0});
      repeat (5) @(negedge clock);
      a0 = 7; b0 = 0;
      repeat (3) @(negedge clock);
      n_vec++;
      if (div_operandA !== 32'd1000 || div_operandB !== 32'd10) begin
         n_err++;
         $display("FAIL operand_hold: got A=%0d B=%0d want A=1000 B=10", div_operandA, div_operandB);
      end
      wait_done(id, at);
      req0 = 0;
      e = sb.pop_front();
      n_vec++;
      if (id !== e.id || result !== e.res || exception !== e.exc) begin
         n_err++;
         $display("FAIL operand_result: got id=%0d res=%0d exc=%b want id=%0d res=%0d exc=%b",
                  id, result, exception, e.id, e.res, e.exc);
      end
      @(negedge clock);
   endtask

   initial begin
      div_result = 0;
      div_exception = 0;
      div_resultRDY = 0;
      test_reset();
      test_basic();
      test_round_robin();
      test_div_by_zero();
      test_timeout();
      test_reset_mid();
      test_operand_hold();
      n_vec++;
      if (both_seen) begin n_err++; $display("FAIL done_exclusive: done0 and done1 high together, want never"); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
